// File: rtl/sw_debounce.sv
// Slide-switch synchroniser, debouncer and edge detector with optional sticky event flags.
// Optional sticky event register: define SW_DEBOUNCE_EVT_LATCH_EN to build it.
module sw_debounce #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 8
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o,
    output logic [WIDTH-1:0] evt_o,
    input  logic             evt_clr_i
);

    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]            s1_q;
    logic [WIDTH-1:0]            s2_q;
    logic [TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic                        tick_c;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            sw_q, sw_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        chg_q, chg_d;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_i;
            s2_q <= s1_q;
        end
    end

    // Free-running prescaler; tick marks its last count.
    assign tick_c = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
        if (tick_c) begin
            tick_cnt_d = '0;
        end
    end

    // Per-bit stability counters: a glitch back to the held level discards progress.
    always_comb begin
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_c && (cnt_q[i] == CNT_LAST)) begin
                cnt_d[i]  = '0;
                sw_d[i]   = s2_q[i];
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else if (tick_c) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        chg_d = (|rise_d) | (|fall_d);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tick_cnt_q <= '0;
            cnt_q      <= '0;
            sw_q       <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            chg_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            cnt_q      <= cnt_d;
            sw_q       <= sw_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            chg_q      <= chg_d;
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = chg_q;

`ifdef SW_DEBOUNCE_EVT_LATCH_EN
    logic [WIDTH-1:0] evt_q, evt_d;

    // Sticky flags: a strobe in the same cycle as a clear keeps its bit set.
    always_comb begin
        evt_d = evt_q;
        if (evt_clr_i) begin
            evt_d = '0;
        end
        evt_d = evt_d | rise_q | fall_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = evt_clr_i;
    assign evt_o          = '0;
`endif

endmodule
